// File: rtl/debug_dmi_master.sv
// rtl/debug_dmi_master.sv - DTM-side DMI initiator with sticky status and dtmcs image
module debug_dmi_master #(
   parameter int ABITS       = 7,
   parameter int IDLE_CYCLES = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ_VALID,
   input  logic [ABITS-1:0] REQ_AD,
   input  logic [31:0]      REQ_DATA,
   input  logic [1:0]       REQ_OP,
   input  logic             DMIRESET,
   input  logic             DMIHARDRESET,
   output logic [ABITS-1:0] RSP_AD,
   output logic [31:0]      RSP_DATA,
   output logic [1:0]       RSP_OP,
   output logic             BUSY,
   output logic [31:0]      DTMCS,
   output logic             DMI_CS,
   output logic             DMI_WR,
   output logic             DMI_RD,
   output logic [ABITS-1:0] DMI_AD,
   output logic [31:0]      DMI_DI,
   input  logic [31:0]      DMI_DO
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE_WR = 3'd1,
      S_ISSUE_RD = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_HOLD     = 3'd4
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'd0;
   localparam logic [1:0] OP_READ = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_FAILED = 2'd2;
   localparam logic [1:0] ST_BUSY   = 2'd3;

   localparam logic [2:0] IDLE3     = 3'(IDLE_CYCLES);
   localparam logic [5:0] ABITS6    = 6'(ABITS);
   // HOLD runs for IDLE_CYCLES cycles, so the counter is loaded one short.
   localparam logic [2:0] HOLD_LOAD = (IDLE_CYCLES > 0) ? 3'(IDLE_CYCLES - 1) : 3'd0;
   localparam state_t     POST_ACCESS = (IDLE_CYCLES > 0) ? S_HOLD : S_IDLE;

   state_t           state_q;
   logic [2:0]       cnt_q;
   logic             cs_q;
   logic             wr_q;
   logic             rd_q;
   logic [ABITS-1:0] dmi_ad_q;
   logic [31:0]      dmi_di_q;
   logic [ABITS-1:0] rsp_ad_q;
   logic [31:0]      rsp_data_q;
   logic [1:0]       rsp_op_q;
   logic [1:0]       rsp_op_d;

   // Status seen by this cycle's request: DMIRESET clears before the request is judged.
   always_comb begin
      rsp_op_d = DMIRESET ? ST_OK : rsp_op_q;
   end

   // Access sequencer, strobe generation, response capture and sticky status.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         dmi_ad_q   <= '0;
         dmi_di_q   <= 32'd0;
         rsp_ad_q   <= '0;
         rsp_data_q <= 32'd0;
         rsp_op_q   <= ST_OK;
      end else begin
         // Strobes are single-cycle: they drop unless re-armed by an accept below.
         cs_q <= 1'b0;
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         if (DMIHARDRESET) begin
            // Abort outright; a request arriving alongside is discarded.
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            rsp_op_q <= ST_OK;
         end else begin
            rsp_op_q <= rsp_op_d;
            case (state_q)
               S_IDLE: begin
                  if (REQ_VALID && (rsp_op_d == ST_OK)) begin
                     rsp_ad_q <= REQ_AD;
                     case (REQ_OP)
                        OP_READ: begin
                           state_q  <= S_ISSUE_RD;
                           cs_q     <= 1'b1;
                           rd_q     <= 1'b1;
                           dmi_ad_q <= REQ_AD;
                           dmi_di_q <= REQ_DATA;
                        end
                        OP_WRITE: begin
                           state_q  <= S_ISSUE_WR;
                           cs_q     <= 1'b1;
                           wr_q     <= 1'b1;
                           dmi_ad_q <= REQ_AD;
                           dmi_di_q <= REQ_DATA;
                        end
                        OP_NOP: begin
                           state_q <= S_IDLE;
                        end
                        default: begin
                           rsp_op_q <= ST_FAILED;
                        end
                     endcase
                  end
               end
               S_ISSUE_WR: begin
                  // The write data is echoed back so the next capture shows it.
                  rsp_data_q <= dmi_di_q;
                  state_q    <= POST_ACCESS;
                  cnt_q      <= HOLD_LOAD;
               end
               S_ISSUE_RD: begin
                  state_q <= S_RD_WAIT;
               end
               S_RD_WAIT: begin
                  // The DM registers its read data, so it is valid one cycle after RD.
                  rsp_data_q <= DMI_DO;
                  state_q    <= POST_ACCESS;
                  cnt_q      <= HOLD_LOAD;
               end
               S_HOLD: begin
                  if (cnt_q == 3'd0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 3'd1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
            // A request landing mid-access is dropped and flagged, keeping any earlier code.
            if ((state_q != S_IDLE) && REQ_VALID && (rsp_op_d == ST_OK)) begin
               rsp_op_q <= ST_BUSY;
            end
         end
      end
   end

   assign BUSY     = (state_q != S_IDLE);
   assign DMI_CS   = cs_q;
   assign DMI_WR   = wr_q;
   assign DMI_RD   = rd_q;
   assign DMI_AD   = dmi_ad_q;
   assign DMI_DI   = dmi_di_q;
   assign RSP_AD   = rsp_ad_q;
   assign RSP_DATA = rsp_data_q;
   assign RSP_OP   = rsp_op_q;
   assign DTMCS    = {14'd0, 1'b0, 1'b0, 1'b0, IDLE3, rsp_op_q, ABITS6, 4'd1};

endmodule

// File: tb/tb_debug_dmi_master.sv
// tb/tb_debug_dmi_master.sv - directed scoreboard bench for debug_dmi_master
module tb_debug_dmi_master;

   logic        CLK;
   logic        RST_N;

   // Instance 0: default parameters (ABITS=7, IDLE_CYCLES=1)
   logic        rv0, drst0, dhrst0;
   logic [6:0]  ad0;
   logic [31:0] dat0;
   logic [1:0]  op0;
   logic [6:0]  rsp_ad0;
   logic [31:0] rsp_data0;
   logic [1:0]  rsp_op0;
   logic        busy0;
   logic [31:0] dtmcs0;
   logic        cs0, wr0, rd0;
   logic [6:0]  dmi_ad0;
   logic [31:0] dmi_di0;
   logic [31:0] do0;
   logic [31:0] dm_ret;

   // Instance 1: ABITS=7, IDLE_CYCLES=0
   logic        rv1, drst1, dhrst1;
   logic [6:0]  ad1;
   logic [31:0] dat1;
   logic [1:0]  op1;
   logic [6:0]  rsp_ad1;
   logic [31:0] rsp_data1;
   logic [1:0]  rsp_op1;
   logic        busy1;
   logic [31:0] dtmcs1;
   logic        cs1, wr1, rd1;
   logic [6:0]  dmi_ad1;
   logic [31:0] dmi_di1;
   logic [31:0] do1;

   int n_vec;
   int n_err;

   logic [41:0] q0[$];
   logic [41:0] q1[$];

   debug_dmi_master #(.ABITS(7), .IDLE_CYCLES(1)) dut0 (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(rv0), .REQ_AD(ad0), .REQ_DATA(dat0), .REQ_OP(op0),
      .DMIRESET(drst0), .DMIHARDRESET(dhrst0),
      .RSP_AD(rsp_ad0), .RSP_DATA(rsp_data0), .RSP_OP(rsp_op0),
      .BUSY(busy0), .DTMCS(dtmcs0),
      .DMI_CS(cs0), .DMI_WR(wr0), .DMI_RD(rd0),
      .DMI_AD(dmi_ad0), .DMI_DI(dmi_di0), .DMI_DO(do0)
   );

   debug_dmi_master #(.ABITS(7), .IDLE_CYCLES(0)) dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(rv1), .REQ_AD(ad1), .REQ_DATA(dat1), .REQ_OP(op1),
      .DMIRESET(drst1), .DMIHARDRESET(dhrst1),
      .RSP_AD(rsp_ad1), .RSP_DATA(rsp_data1), .RSP_OP(rsp_op1),
      .BUSY(busy1), .DTMCS(dtmcs1),
      .DMI_CS(cs1), .DMI_WR(wr1), .DMI_RD(rd1),
      .DMI_AD(dmi_ad1), .DMI_DI(dmi_di1), .DMI_DO(do1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Debug Module read port model: registered read data, one cycle after RD.
   always @(posedge CLK) begin
      if (cs0 && rd0) do0 <= dm_ret;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then compare any DMI strobe against the scoreboards.
   task automatic tick();
      logic [41:0] e;
      @(posedge CLK);
      #1;
      if (cs0 || wr0 || rd0) begin
         if (q0.size() == 0) begin
            check("unexpected_strobe0", {61'd0, cs0, wr0, rd0}, 64'd0);
         end else begin
            e = q0.pop_front();
            check("strobe0", {22'd0, cs0, wr0, rd0, dmi_ad0, dmi_di0}, {22'd0, e});
         end
      end
      if (cs1 || wr1 || rd1) begin
         if (q1.size() == 0) begin
            check("unexpected_strobe1", {61'd0, cs1, wr1, rd1}, 64'd0);
         end else begin
            e = q1.pop_front();
            check("strobe1", {22'd0, cs1, wr1, rd1, dmi_ad1, dmi_di1}, {22'd0, e});
         end
      end
   endtask

   task automatic req0(input logic [1:0] op, input logic [6:0] ad, input logic [31:0] d,
                       input bit strobe);
      if (strobe) q0.push_back({1'b1, (op == 2'd2), (op == 2'd1), ad, d});
      rv0 = 1'b1; op0 = op; ad0 = ad; dat0 = d;
      tick();
      rv0 = 1'b0; op0 = 2'd0;
   endtask

   task automatic req1(input logic [6:0] ad, input logic [31:0] d);
      q1.push_back({3'b110, ad, d});
      rv1 = 1'b1; op1 = 2'd2; ad1 = ad; dat1 = d;
      tick();
      rv1 = 1'b0; op1 = 2'd0;
   endtask

   task automatic wait_idle0();
      int k;
      k = 0;
      while (busy0 && k < 20) begin
         tick();
         k++;
      end
      check("idle_timeout0", {63'd0, busy0}, 64'd0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      RST_N = 1'b0;
      rv0 = 0; drst0 = 0; dhrst0 = 0; ad0 = 0; dat0 = 0; op0 = 0; do0 = 0; dm_ret = 0;
      rv1 = 0; drst1 = 0; dhrst1 = 0; ad1 = 0; dat1 = 0; op1 = 0; do1 = 0;
      #2;
      // Reset state
      check("rst_busy", {63'd0, busy0}, 64'd0);
      check("rst_strobes", {61'd0, cs0, wr0, rd0}, 64'd0);
      check("rst_dmi_ad_di", {25'd0, dmi_ad0, dmi_di0}, 64'd0);
      check("rst_rsp", {23'd0, rsp_ad0, rsp_data0, rsp_op0}, 64'd0);
      check("dtmcs_default", {32'd0, dtmcs0}, 64'h1071);
      check("dtmcs_idle0", {32'd0, dtmcs1}, 64'h0071);
      #10 RST_N = 1'b1;
      tick(); tick();

      // 1. Write
      req0(2'd2, 7'h10, 32'h8000_0001, 1'b1);
      check("wr_busy_strobe", {63'd0, busy0}, 64'd1);
      tick();
      check("wr_busy_hold", {63'd0, busy0}, 64'd1);
      tick();
      check("wr_busy_done", {63'd0, busy0}, 64'd0);
      check("wr_rsp_op", {62'd0, rsp_op0}, 64'd0);
      check("wr_rsp_data", {32'd0, rsp_data0}, 64'h8000_0001);
      check("wr_rsp_ad", {57'd0, rsp_ad0}, 64'h10);

      // 2. Read
      dm_ret = 32'h0000_0C82;
      req0(2'd1, 7'h11, 32'h0, 1'b1);
      check("rd_data_c1", {32'd0, rsp_data0}, 64'h8000_0001);
      tick();
      check("rd_data_c2", {32'd0, rsp_data0}, 64'h8000_0001);
      tick();
      check("rd_data_c3", {32'd0, rsp_data0}, 64'h0000_0C82);
      wait_idle0();
      check("rd_rsp_op", {62'd0, rsp_op0}, 64'd0);

      // 3. Busy error
      req0(2'd2, 7'h12, 32'hAAAA_5555, 1'b1);
      req0(2'd2, 7'h13, 32'h0000_1234, 1'b0);
      check("busy_rsp_op", {62'd0, rsp_op0}, 64'd3);
      wait_idle0();
      check("busy_inflight_data", {32'd0, rsp_data0}, 64'hAAAA_5555);
      req0(2'd2, 7'h14, 32'h0000_4444, 1'b0);
      tick();
      check("sticky_rsp_op", {62'd0, rsp_op0}, 64'd3);
      check("sticky_rsp_ad", {57'd0, rsp_ad0}, 64'h12);
      check("sticky_busy", {63'd0, busy0}, 64'd0);
      drst0 = 1'b1;
      tick();
      drst0 = 1'b0;
      check("dmireset_clear", {62'd0, rsp_op0}, 64'd0);
      req0(2'd2, 7'h15, 32'h1515_1515, 1'b1);
      wait_idle0();
      check("post_reset_write", {32'd0, rsp_data0}, 64'h1515_1515);

      // 4. Reserved op and nop
      req0(2'd0, 7'h23, 32'h0, 1'b0);
      check("nop_rsp_ad", {57'd0, rsp_ad0}, 64'h23);
      check("nop_busy", {63'd0, busy0}, 64'd0);
      req0(2'd3, 7'h20, 32'h0, 1'b0);
      check("rsvd_rsp_op", {62'd0, rsp_op0}, 64'd2);
      check("rsvd_rsp_ad", {57'd0, rsp_ad0}, 64'h20);
      check("rsvd_dtmcs", {32'd0, dtmcs0}, 64'h1871);
      req0(2'd0, 7'h21, 32'h0, 1'b0);
      check("rsvd_nop_op", {62'd0, rsp_op0}, 64'd2);
      check("rsvd_nop_ad", {57'd0, rsp_ad0}, 64'h20);
      // Clear and request in the same cycle: request goes through.
      drst0 = 1'b1;
      req0(2'd2, 7'h22, 32'h2222_2222, 1'b1);
      drst0 = 1'b0;
      check("clr_req_op", {62'd0, rsp_op0}, 64'd0);
      check("clr_req_ad", {57'd0, rsp_ad0}, 64'h22);
      wait_idle0();

      // 5. Hard reset during RD_WAIT
      dm_ret = 32'hDEAD_BEEF;
      req0(2'd1, 7'h30, 32'h0, 1'b1);
      req0(2'd2, 7'h31, 32'h0000_0009, 1'b0);
      check("abort_pre_op", {62'd0, rsp_op0}, 64'd3);
      check("abort_pre_busy", {63'd0, busy0}, 64'd1);
      dhrst0 = 1'b1;
      tick();
      dhrst0 = 1'b0;
      check("abort_busy", {63'd0, busy0}, 64'd0);
      check("abort_op", {62'd0, rsp_op0}, 64'd0);
      check("abort_data", {32'd0, rsp_data0}, 64'h2222_2222);
      tick(); tick();
      check("abort_data_later", {32'd0, rsp_data0}, 64'h2222_2222);

      // Async reset while the write strobe is out
      req0(2'd2, 7'h31, 32'h0000_0005, 1'b1);
      #1 RST_N = 1'b0;
      #1;
      check("arst_strobes", {61'd0, cs0, wr0, rd0}, 64'd0);
      check("arst_busy", {63'd0, busy0}, 64'd0);
      check("arst_dmi", {25'd0, dmi_ad0, dmi_di0}, 64'd0);
      check("arst_rsp", {23'd0, rsp_ad0, rsp_data0, rsp_op0}, 64'd0);
      #1 RST_N = 1'b1;
      tick(); tick();

      // 6. IDLE_CYCLES=0: writes every second cycle
      for (int i = 0; i < 4; i++) begin
         req1(7'(8'h40 + i), 32'hC0DE_0000 + i);
         tick();
      end
      check("b2b_rsp_op", {62'd0, rsp_op1}, 64'd0);
      check("b2b_rsp_data", {32'd0, rsp_data1}, 64'hC0DE_0003);
      check("b2b_rsp_ad", {57'd0, rsp_ad1}, 64'h43);
      check("b2b_busy", {63'd0, busy1}, 64'd0);
      check("b2b_dtmcs", {32'd0, dtmcs1}, 64'h0071);

      tick(); tick();
      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
